// File: rtl/axi_lite_regbus_bridge.sv
// axi_lite_regbus_bridge
// Terminates an AXI4-Lite slave port and turns each read or write into a
// single strobe/ack transaction on the internal register bus. A missing
// bus_ack is converted into an SLVERR response after TIMEOUT cycles, so
// every AXI transaction always completes.
//
// Ports:
//   clk, rst                      single clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*               AXI4-Lite write address/data/response channels
//   s_ar*/s_r*                    AXI4-Lite read address/data channels
//   bus_addr/bus_wdata/bus_be     register bus request (address word-aligned)
//   bus_wr/bus_rd                 one-cycle write/read strobes
//   bus_rdata/bus_ack             register bus completion
module axi_lite_regbus_bridge #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  output logic                  bus_wr,
  output logic                  bus_rd,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("axi_lite_regbus_bridge: DATA_W must be 32");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("axi_lite_regbus_bridge: TIMEOUT must be in 1..65535");
  end

  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
  // Last counter value still inside the ack window; the response state is
  // entered on the edge where the counter would reach TIMEOUT.
  localparam logic [15:0]       CNT_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_BUS, WR_RESP, RD_BUS, RD_RESP
  } state_t;

  state_t                state_q, state_nxt;
  logic                  aw_lat_q, w_lat_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   be_q;
  logic [15:0]           cnt_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_W-1:0]     rdata_q;

  logic aw_hs, w_hs, ar_hs;
  logic ack_seen, timed_out;

  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  always_comb begin
    state_nxt = state_q;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_arready = 1'b0;
    s_bvalid  = 1'b0;
    s_rvalid  = 1'b0;
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    ar_hs     = 1'b0;
    ack_seen  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE, WR_COLLECT: begin
        // Readies are held low while rst is asserted so the port looks idle.
        s_awready = !aw_lat_q && !rst;
        s_wready  = !w_lat_q && !rst;
        // Reads only start when no write is pending or being offered.
        s_arready = (state_q == IDLE) && !aw_lat_q && !w_lat_q &&
                    !s_awvalid && !s_wvalid && !rst;
        aw_hs = s_awvalid && s_awready;
        w_hs  = s_wvalid && s_wready;
        ar_hs = s_arvalid && s_arready;
        if ((aw_lat_q || aw_hs) && (w_lat_q || w_hs))
          state_nxt = WR_BUS;
        else if (aw_hs || w_hs)
          state_nxt = WR_COLLECT;
        else if (ar_hs)
          state_nxt = RD_BUS;
      end
      WR_BUS, RD_BUS: begin
        bus_wr    = (state_q == WR_BUS) && (cnt_q == 16'd0);
        bus_rd    = (state_q == RD_BUS) && (cnt_q == 16'd0);
        ack_seen  = bus_ack;
        timed_out = !bus_ack && (cnt_q == CNT_LAST);
        if (ack_seen || timed_out)
          state_nxt = (state_q == WR_BUS) ? WR_RESP : RD_RESP;
      end
      WR_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) state_nxt = IDLE;
      end
      RD_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      aw_lat_q <= 1'b0;
      w_lat_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      bresp_q  <= RESP_OKAY;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      state_q <= state_nxt;
      if (aw_hs) begin
        aw_lat_q <= 1'b1;
        addr_q   <= s_awaddr & ALIGN_MASK;
      end
      if (w_hs) begin
        w_lat_q <= 1'b1;
        wdata_q <= s_wdata;
        be_q    <= s_wstrb;
      end
      if (ar_hs)
        addr_q <= s_araddr & ALIGN_MASK;
      // Counter is 0 in the strobe cycle and only runs inside a bus state.
      if (state_q == WR_BUS || state_q == RD_BUS)
        cnt_q <= cnt_q + 16'd1;
      else
        cnt_q <= '0;
      if (state_q == WR_BUS && (ack_seen || timed_out)) begin
        bresp_q  <= ack_seen ? RESP_OKAY : RESP_SLVERR;
        aw_lat_q <= 1'b0;
        w_lat_q  <= 1'b0;
      end
      if (state_q == RD_BUS && (ack_seen || timed_out)) begin
        rresp_q <= ack_seen ? RESP_OKAY : RESP_SLVERR;
        rdata_q <= ack_seen ? bus_rdata : ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_regbus_bridge.sv
module tb_axi_lite_regbus_bridge;

  logic        clk;
  logic        rst;
  logic [15:0] s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [15:0] s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_wr;
  logic        bus_rd;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int errors = 0;
  int checks = 0;

  axi_lite_regbus_bridge #(
    .ADDR_W  (16),
    .DATA_W  (32),
    .TIMEOUT (8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_awaddr (s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_wvalid (s_wvalid),
    .s_wready (s_wready),
    .s_bresp  (s_bresp),
    .s_bvalid (s_bvalid),
    .s_bready (s_bready),
    .s_araddr (s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata  (s_rdata),
    .s_rresp  (s_rresp),
    .s_rvalid (s_rvalid),
    .s_rready (s_rready),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be   (bus_be),
    .bus_wr   (bus_wr),
    .bus_rd   (bus_rd),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at the falling edge; outputs are checked 1 ns later and
  // the rising edge in the middle of the next half period samples both.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {awready, wready, arready, bvalid, rvalid, bus_wr, bus_rd}
  function automatic logic [31:0] ctl();
    return {25'd0, s_awready, s_wready, s_arready, s_bvalid, s_rvalid, bus_wr, bus_rd};
  endfunction

  initial begin
    rst = 1'b1;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    bus_rdata = '0; bus_ack = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_addr", {16'd0, bus_addr}, 32'h0);
    chk("reset_rdata", s_rdata, 32'h0);
    cyc(); rst = 1'b0; #1;
    chk("idle_ready", ctl(), 32'b111_0000);

    // AW+W together, ack in strobe cycle
    cyc(); s_awvalid = 1'b1; s_awaddr = 16'h0104; s_wvalid = 1'b1;
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; #1;
    chk("t1_hs", ctl(), 32'b110_0000);
    cyc(); s_awvalid = 1'b0; s_wvalid = 1'b0; bus_ack = 1'b1; #1;
    chk("t1_strobe", ctl(), 32'b000_0010);
    chk("t1_addr", {16'd0, bus_addr}, 32'h0104);
    chk("t1_wdata", bus_wdata, 32'h1234_5678);
    chk("t1_be", {28'd0, bus_be}, 32'hF);
    cyc(); bus_ack = 1'b0; s_bready = 1'b1; #1;
    chk("t1_bvalid", ctl(), 32'b000_1000);
    chk("t1_bresp", {30'd0, s_bresp}, 32'h0);
    cyc(); s_bready = 1'b0; #1;
    chk("t1_done", ctl(), 32'b111_0000);

    // W three cycles before AW, arvalid held high throughout
    cyc(); s_wvalid = 1'b1; s_wdata = 32'hA5A5_0F0F; s_wstrb = 4'b0011;
    s_arvalid = 1'b1; s_araddr = 16'h0300; #1;
    chk("t2_w_only", ctl(), 32'b110_0000);
    cyc(); s_wvalid = 1'b0; #1;
    chk("t2_collect1", ctl(), 32'b100_0000);
    cyc(); #1;
    chk("t2_collect2", ctl(), 32'b100_0000);
    cyc(); s_awvalid = 1'b1; s_awaddr = 16'h0010; #1;
    chk("t2_aw", ctl(), 32'b100_0000);
    cyc(); s_awvalid = 1'b0; #1;
    chk("t2_strobe", ctl(), 32'b000_0010);
    chk("t2_addr", {16'd0, bus_addr}, 32'h0010);
    chk("t2_be", {28'd0, bus_be}, 32'h3);
    chk("t2_wdata", bus_wdata, 32'hA5A5_0F0F);
    cyc(); bus_ack = 1'b1; #1;
    chk("t2_wait", ctl(), 32'b000_0000);
    cyc(); bus_ack = 1'b0; s_bready = 1'b1; #1;
    chk("t2_bvalid", ctl(), 32'b000_1000);
    cyc(); s_bready = 1'b0; #1;
    chk("t2_ar_ready", ctl(), 32'b111_0000);
    cyc(); s_arvalid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1122_3344; #1;
    chk("t2_rd_strobe", ctl(), 32'b000_0001);
    chk("t2_rd_addr", {16'd0, bus_addr}, 32'h0300);
    cyc(); bus_ack = 1'b0; s_rready = 1'b1; #1;
    chk("t2_rvalid", ctl(), 32'b000_0100);
    chk("t2_rdata", s_rdata, 32'h1122_3344);
    cyc(); s_rready = 1'b0;

    // Read 0x0200, ack 5 cycles after bus_rd, rready low for 4 cycles
    cyc(); s_arvalid = 1'b1; s_araddr = 16'h0200; #1;
    chk("t3_ar", ctl(), 32'b111_0000);
    cyc(); s_arvalid = 1'b0; #1;
    chk("t3_strobe", ctl(), 32'b000_0001);
    chk("t3_addr", {16'd0, bus_addr}, 32'h0200);
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      chk("t3_wait", ctl(), 32'b000_0000);
    end
    cyc(); bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D; #1;
    chk("t3_ack", ctl(), 32'b000_0000);
    cyc(); bus_ack = 1'b0; bus_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_rvalid_hold", ctl(), 32'b000_0100);
      chk("t3_rdata_hold", s_rdata, 32'hCAFE_F00D);
      chk("t3_rresp_hold", {30'd0, s_rresp}, 32'h0);
      cyc();
    end
    s_rready = 1'b1; #1;
    chk("t3_rvalid_hs", ctl(), 32'b000_0100);
    chk("t3_rdata_hs", s_rdata, 32'hCAFE_F00D);
    cyc(); s_rready = 1'b0; #1;
    chk("t3_done", ctl(), 32'b111_0000);

    // Timeout: no ack, unaligned address, late ack ignored
    cyc(); s_arvalid = 1'b1; s_araddr = 16'h0047; #1;
    chk("t4_ar", ctl(), 32'b111_0000);
    cyc(); s_arvalid = 1'b0; #1;
    chk("t4_strobe", ctl(), 32'b000_0001);
    chk("t4_addr", {16'd0, bus_addr}, 32'h0044);
    for (int k = 1; k <= 7; k++) begin
      cyc(); #1;
      chk("t4_wait", ctl(), 32'b000_0000);
    end
    cyc(); bus_ack = 1'b1; bus_rdata = 32'h5555_5555; #1;
    chk("t4_rvalid", ctl(), 32'b000_0100);
    chk("t4_rresp", {30'd0, s_rresp}, 32'h2);
    chk("t4_rdata", s_rdata, 32'hDEAD_BEEF);
    cyc(); bus_ack = 1'b0; s_rready = 1'b1; #1;
    chk("t4_late_ack_rdata", s_rdata, 32'hDEAD_BEEF);
    chk("t4_late_ack_rresp", {30'd0, s_rresp}, 32'h2);
    cyc(); s_rready = 1'b0; bus_ack = 1'b1; #1;
    chk("t4_idle_ack", ctl(), 32'b111_0000);
    cyc(); bus_ack = 1'b0; #1;
    chk("t4_idle_after", ctl(), 32'b111_0000);

    // AW, W and AR together: write first, wstrb=0000
    cyc(); s_awvalid = 1'b1; s_awaddr = 16'h0020; s_wvalid = 1'b1;
    s_wdata = 32'h0000_00FF; s_wstrb = 4'b0000; s_arvalid = 1'b1; s_araddr = 16'h0400; #1;
    chk("t5_hs", ctl(), 32'b110_0000);
    cyc(); s_awvalid = 1'b0; s_wvalid = 1'b0; bus_ack = 1'b1; #1;
    chk("t5_strobe", ctl(), 32'b000_0010);
    chk("t5_be", {28'd0, bus_be}, 32'h0);
    chk("t5_addr", {16'd0, bus_addr}, 32'h0020);
    cyc(); bus_ack = 1'b0; #1;
    chk("t5_bvalid", ctl(), 32'b000_1000);
    cyc(); s_bready = 1'b1; #1;
    chk("t5_bvalid_hs", ctl(), 32'b000_1000);
    cyc(); s_bready = 1'b0; #1;
    chk("t5_ar", ctl(), 32'b111_0000);
    cyc(); s_arvalid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D; #1;
    chk("t5_rd_strobe", ctl(), 32'b000_0001);
    chk("t5_rd_addr", {16'd0, bus_addr}, 32'h0400);
    cyc(); bus_ack = 1'b0; s_rready = 1'b1; #1;
    chk("t5_rvalid", ctl(), 32'b000_0100);
    chk("t5_rdata", s_rdata, 32'h0BAD_F00D);
    cyc(); s_rready = 1'b0;

    // Reset during WR_BUS, then a normal read
    cyc(); s_awvalid = 1'b1; s_awaddr = 16'h0008; s_wvalid = 1'b1;
    s_wdata = 32'h0000_0077; s_wstrb = 4'hF; #1;
    chk("t6_hs", ctl(), 32'b110_0000);
    cyc(); s_awvalid = 1'b0; s_wvalid = 1'b0; #1;
    chk("t6_strobe", ctl(), 32'b000_0010);
    rst = 1'b1;
    cyc(); #1;
    chk("t6_rst_ctl", ctl(), 32'h0);
    chk("t6_rst_addr", {16'd0, bus_addr}, 32'h0);
    chk("t6_rst_wdata", bus_wdata, 32'h0);
    chk("t6_rst_be", {28'd0, bus_be}, 32'h0);
    chk("t6_rst_rdata", s_rdata, 32'h0);
    chk("t6_rst_resp", {28'd0, s_bresp, s_rresp}, 32'h0);
    rst = 1'b0;
    cyc(); #1;
    chk("t6_idle", ctl(), 32'b111_0000);
    cyc(); s_arvalid = 1'b1; s_araddr = 16'h0100; #1;
    chk("t6_ar", ctl(), 32'b111_0000);
    cyc(); s_arvalid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF; #1;
    chk("t6_rd_strobe", ctl(), 32'b000_0001);
    chk("t6_rd_addr", {16'd0, bus_addr}, 32'h0100);
    cyc(); bus_ack = 1'b0; s_rready = 1'b1; #1;
    chk("t6_rvalid", ctl(), 32'b000_0100);
    chk("t6_rdata", s_rdata, 32'h1357_9BDF);
    chk("t6_rresp", {30'd0, s_rresp}, 32'h0);
    cyc(); s_rready = 1'b0; #1;
    chk("t6_done", ctl(), 32'b111_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
